// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM encoding and sizing for the sequential shift-add multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int DEF_WIDTH = 32;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/mult_shift_add_dp.sv
// mult_shift_add_dp: operand registers, shift-add accumulator and sign fixup for HI/LO
// Ports: load latches |a|,|b| and sign; step runs one shift-add iteration;
// fix writes {hi,lo} from the accumulator shifted right by rem and negated if needed.
// rest_zero (only with MULT_EARLY_TERM_EN) flags that no multiplier bits remain above bit 0.
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW = cnt_w(WIDTH)
) (
`ifdef MULT_EARLY_TERM_EN
  output logic rest_zero,
`endif
  input logic clk,
  input logic rst_n,
  input logic load,
  input logic step,
  input logic fix,
  input logic sign,
  input logic [WIDTH-1:0] a,
  input logic [WIDTH-1:0] b,
  input logic [CW-1:0] rem,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH-1:0] mcand, mplier, abs_a, abs_b;
  logic [2*WIDTH-1:0] acc, aligned, res;
  logic [WIDTH:0] sum;
  logic neg;
  // the most-negative value negates to itself, which read unsigned is the right magnitude
  assign abs_a = (sign & a[WIDTH-1]) ? -a : a;
  assign abs_b = (sign & b[WIDTH-1]) ? -b : b;
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mplier[0] ? mcand : '0};
  assign aligned = acc >> rem;
  assign res = neg ? -aligned : aligned;
`ifdef MULT_EARLY_TERM_EN
  assign rest_zero = ~|mplier[WIDTH-1:1];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      neg <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (load) begin
        mcand <= abs_a;
        mplier <= abs_b;
        neg <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc <= '0;
      end else if (step) begin
        acc <= {sum, acc[WIDTH-1:1]};
        mplier <= mplier >> 1;
      end
      if (fix) {hi, lo} <= res;
    end
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: multi-cycle MULT/MULTU unit with HI/LO, busy, stall and done
// Ports: start_mult/mult_sign/op_a/op_b issue a multiply; rd_hi/rd_lo flag MFHI/MFLO
// in decode; hi_out/lo_out are HI/LO; busy while not IDLE; stall freezes the pipe
// while a dependent op waits; done pulses one cycle when HI/LO get a new result.
// Build option MULT_EARLY_TERM_EN: leave CALC once the remaining multiplier bits are zero.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst_n,
  input logic start_mult,
  input logic mult_sign,
  input logic [WIDTH-1:0] op_a,
  input logic [WIDTH-1:0] op_b,
  input logic rd_hi,
  input logic rd_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic busy,
  output logic stall,
  output logic done
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, nxt;
  logic [CW-1:0] cnt, rem;
  logic last, load;
  assign busy = state != IDLE;
  assign stall = busy & (rd_hi | rd_lo | start_mult);
  assign load = (state == IDLE) & start_mult;
`ifdef MULT_EARLY_TERM_EN
  logic rest_zero;
  // cnt counts iterations done; the unshifted remainder still has to be applied
  assign last = rest_zero | (cnt == CW'(WIDTH - 1));
  assign rem = CW'(WIDTH) - cnt;
`else
  assign last = cnt == CW'(WIDTH - 1);
  assign rem = '0;
`endif
  always_comb
    nxt = (state == IDLE) ? (start_mult ? CALC : IDLE) :
          (state == CALC) ? (last ? FIX : CALC) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      done <= 1'b0;
    end else begin
      cnt <= load ? '0 : (state == CALC) ? cnt + 1'b1 : cnt;
      done <= state == FIX;
    end
  mult_shift_add_dp #(.WIDTH(WIDTH), .CW(CW)) u_dp (
`ifdef MULT_EARLY_TERM_EN
    .rest_zero(rest_zero),
`endif
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .step(state == CALC),
    .fix(state == FIX),
    .sign(mult_sign),
    .a(op_a),
    .b(op_b),
    .rem(rem),
    .hi(hi_out),
    .lo(lo_out)
  );
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: scoreboard bench for mult_sequencer (either MULT_EARLY_TERM_EN setting)
module tb_mult_sequencer;
`ifdef MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start_mult = 1'b0, mult_sign = 1'b0, rd_hi = 1'b0, rd_lo = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, hi_out, lo_out;
  logic busy, stall, done;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] q[$];
  always #5 clk = ~clk;
  mult_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_mult(start_mult), .mult_sign(mult_sign),
    .op_a(op_a), .op_b(op_b), .rd_hi(rd_hi), .rd_lo(rd_lo),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall(stall), .done(done)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'h0, a};
    xb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return xa * xb;
  endfunction
  function automatic int exp_busy(input logic [31:0] b, input logic s);
    logic [31:0] m;
    int k;
    m = (s && b[31]) ? -b : b;
    k = 0;
    for (int i = 0; i < 32; i++) if (m[i]) k = i;
    return ET ? 2 + k : 33;
  endfunction
  always @(negedge clk)
    if (done) begin
      if (q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else chk("result", {hi_out, lo_out}, q.pop_front());
    end
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int rd_at = 0, input int poke_at = 0, input bit chain = 0);
    logic [63:0] e, prev;
    int cyc;
    e = model(a, b, s);
    prev = {hi_out, lo_out};
    op_a = a;
    op_b = b;
    mult_sign = s;
    start_mult = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    mult_sign = ~s;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (cyc == rd_at) rd_hi = 1'b1;
      if (cyc == poke_at) start_mult = 1'b1;
      @(negedge clk);
      if (rd_at > 0 || cyc == poke_at) chk("stall", {63'd0, stall}, {63'd0, rd_hi | start_mult});
      chk("hold", {hi_out, lo_out}, prev);
      @(posedge clk);
      #1;
      start_mult = 1'b0;
    end
    chk("busy_len", 64'(cyc), 64'(exp_busy(b, s)));
    chk("done", {63'd0, done}, 64'd1);
    chk("stall_fall", {63'd0, stall}, 64'd0);
    chk("hi_on_done", {32'd0, hi_out}, {32'd0, e[63:32]});
    rd_hi = 1'b0;
    if (!chain) begin
      @(posedge clk);
      #1;
      chk("done_pulse", {63'd0, done}, 64'd0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("ff_x_ff", {hi_out, lo_out}, 64'hFFFFFFFE_00000001);
    run_mul(32'hFFFFFFFD, 32'd5, 1'b1);
    chk("m3_x_5_s", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFF1);
    run_mul(32'hFFFFFFFD, 32'd5, 1'b0);
    chk("m3_x_5_u", {hi_out, lo_out}, 64'h00000004_FFFFFFF1);
    run_mul(32'h80000000, 32'h80000000, 1'b1);
    chk("min_x_min", {hi_out, lo_out}, 64'h40000000_00000000);
    run_mul(32'h12345678, 32'h9ABCDEF0, 1'b0, 5, 8);
    run_mul(32'hDEADBEEF, 32'h0000F00D, 1'b1, 0, 0, 1'b1);
    run_mul(32'h00000003, 32'h7FFFFFFF, 1'b1);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("m1_x_m1", {hi_out, lo_out}, 64'h00000000_00000001);
    run_mul(32'hCAFEF00D, 32'd0, 1'b1);
    chk("x_by_zero", {hi_out, lo_out}, 64'd0);
    for (int i = 0; i < 6; i++) run_mul($urandom, $urandom >> (5 * i), 1'($urandom_range(0, 1)));
    run_mul(32'h00001234, 32'd1, 1'b0);
    chk("x_by_one", {hi_out, lo_out}, 64'h00000000_00001234);
    op_a = 32'h55555555;
    op_b = 32'hAAAAAAAA;
    mult_sign = 1'b0;
    start_mult = 1'b1;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy_pre_rst", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi_out, lo_out}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no_done_after_rst", {hi_out, lo_out}, 64'd0);
    run_mul(32'd7, 32'd6, 1'b0);
    chk("seven_x_six", {32'd0, lo_out}, 64'd42);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
